// File: rtl/unidade_controle_rodadas_pkg.sv
// Shared definitions for the memory-game round controller: state codes,
// default display timings and a small sizing helper.
package unidade_controle_rodadas_pkg;

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    NOVA_RODADA    = 4'h2,
    MOSTRA         = 4'h3,
    APAGA          = 4'h4,
    AVANCA_MOSTRA  = 4'h5,
    INICIO_JOGADAS = 4'h6,
    ESPERA_JOGADA  = 4'h7,
    REGISTRA       = 4'h8,
    COMPARA        = 4'h9,
    PROXIMA_JOGADA = 4'hA,
    PROXIMA_RODADA = 4'hB,
    FIM_GANHOU     = 4'hC,
    FIM_PERDEU     = 4'hD,
    FIM_TIMEOUT    = 4'hE
  } estado_t;

  localparam int T_LED_PADRAO = 1000;
  localparam int T_GAP_PADRAO = 500;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/unidade_controle_rodadas_if.sv
// Controller <-> datapath bundle: status flags from the datapath, control
// strobes to it. All signals are levels sampled on the rising clock edge.
interface unidade_controle_rodadas_if;
  logic tem_jogada;
  logic jogada_correta;
  logic endereco_igual_rodada;
  logic ultima_rodada;
  logic timeout;
  logic zera_endereco;
  logic conta_endereco;
  logic zera_rodada;
  logic conta_rodada;
  logic zera_timer;
  logic conta_timer;
  logic registra_jogada;
  logic mostra_led;

  modport master (
    input  tem_jogada, jogada_correta, endereco_igual_rodada, ultima_rodada, timeout,
    output zera_endereco, conta_endereco, zera_rodada, conta_rodada,
           zera_timer, conta_timer, registra_jogada, mostra_led
  );

  modport slave (
    output tem_jogada, jogada_correta, endereco_igual_rodada, ultima_rodada, timeout,
    input  zera_endereco, conta_endereco, zera_rodada, conta_rodada,
           zera_timer, conta_timer, registra_jogada, mostra_led
  );
endinterface

// File: rtl/unidade_controle_rodadas_contador_exibicao.sv
// Loadable down-counter for LED on/off intervals; fim is high while the
// count sits at zero, so loading N-1 yields an N-cycle interval.
module contador_exibicao #(
   parameter int W = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         carrega,
   input  logic         habilita,
   input  logic [W-1:0] valor,
   output logic         fim
);

   logic [W-1:0] cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (carrega)
         cnt <= valor;
      else if (habilita && cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign fim = (cnt == '0);

endmodule

// File: rtl/unidade_controle_rodadas.sv
// Moore controller for the memory game: replays the sequence up to the
// current round, then collects and checks the plays; ends in win/loss/timeout.
module unidade_controle_rodadas
   import unidade_controle_rodadas_pkg::*;
#(
   parameter int T_LED = T_LED_PADRAO,
   parameter int T_GAP = T_GAP_PADRAO
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          iniciar,
   unidade_controle_rodadas_if.master    dp,
   output logic                          pronto,
   output logic                          ganhou,
   output logic                          perdeu,
   output logic                          db_timeout,
   output logic [3:0]                    db_estado
);

   localparam int TW = $clog2(max_int(T_LED, T_GAP)) + 1;

   estado_t       estado, prox;
   logic          fim_intervalo;
   logic          carrega;
   logic [TW-1:0] valor_intervalo;

   // Timer reloads only on entry to mostra/apaga, so each lasts its full length.
   assign carrega         = (prox != estado) && (prox == MOSTRA || prox == APAGA);
   assign valor_intervalo = (prox == MOSTRA) ? TW'(T_LED - 1) : TW'(T_GAP - 1);

   contador_exibicao #(.W(TW)) u_contador (
      .clock    (clock),
      .reset    (reset),
      .carrega  (carrega),
      .habilita (estado == MOSTRA || estado == APAGA),
      .valor    (valor_intervalo),
      .fim      (fim_intervalo)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) estado <= INICIAL;
      else       estado <= prox;
   end

   always_comb begin
      prox = estado;
      case (estado)
         INICIAL:        if (iniciar) prox = PREPARACAO;
         PREPARACAO:     prox = MOSTRA;
         NOVA_RODADA:    prox = MOSTRA;
         MOSTRA:         if (fim_intervalo) prox = APAGA;
         APAGA:          if (fim_intervalo)
                            prox = dp.endereco_igual_rodada ? INICIO_JOGADAS : AVANCA_MOSTRA;
         AVANCA_MOSTRA:  prox = MOSTRA;
         INICIO_JOGADAS: prox = ESPERA_JOGADA;
         // A press in the same cycle as the timer expiry counts as a play.
         ESPERA_JOGADA:  if (dp.tem_jogada)   prox = REGISTRA;
                         else if (dp.timeout) prox = FIM_TIMEOUT;
         REGISTRA:       prox = COMPARA;
         COMPARA:        if (!dp.jogada_correta)             prox = FIM_PERDEU;
                         else if (!dp.endereco_igual_rodada) prox = PROXIMA_JOGADA;
                         else if (dp.ultima_rodada)          prox = FIM_GANHOU;
                         else                                prox = PROXIMA_RODADA;
         PROXIMA_JOGADA: prox = ESPERA_JOGADA;
         PROXIMA_RODADA: prox = NOVA_RODADA;
         FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT:
                         if (iniciar) prox = PREPARACAO;
         default:        prox = INICIAL;
      endcase
   end

   always_comb begin
      dp.zera_endereco   = 1'b0;
      dp.conta_endereco  = 1'b0;
      dp.zera_rodada     = 1'b0;
      dp.conta_rodada    = 1'b0;
      dp.zera_timer      = 1'b0;
      dp.conta_timer     = 1'b0;
      dp.registra_jogada = 1'b0;
      dp.mostra_led      = 1'b0;
      pronto             = 1'b0;
      ganhou             = 1'b0;
      perdeu             = 1'b0;
      db_timeout         = 1'b0;
      case (estado)
         PREPARACAO:     begin dp.zera_endereco = 1'b1; dp.zera_rodada = 1'b1; dp.zera_timer = 1'b1; end
         NOVA_RODADA:    dp.zera_endereco = 1'b1;
         MOSTRA:         dp.mostra_led = 1'b1;
         AVANCA_MOSTRA:  dp.conta_endereco = 1'b1;
         INICIO_JOGADAS: begin dp.zera_endereco = 1'b1; dp.zera_timer = 1'b1; end
         ESPERA_JOGADA:  dp.conta_timer = 1'b1;
         REGISTRA:       begin dp.registra_jogada = 1'b1; dp.zera_timer = 1'b1; end
         PROXIMA_JOGADA: begin dp.conta_endereco = 1'b1; dp.zera_timer = 1'b1; end
         PROXIMA_RODADA: dp.conta_rodada = 1'b1;
         FIM_GANHOU:     begin pronto = 1'b1; ganhou = 1'b1; end
         FIM_PERDEU:     begin pronto = 1'b1; perdeu = 1'b1; end
         FIM_TIMEOUT:    begin pronto = 1'b1; perdeu = 1'b1; db_timeout = 1'b1; end
         default:        ;
      endcase
   end

   assign db_estado = estado;

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// Directed bench for the round controller with a small address/round
// counter stand-in for the datapath; inputs driven and outputs sampled at negedge.
module tb_unidade_controle_rodadas;
  import unidade_controle_rodadas_pkg::*;

  localparam int TL = 4;
  localparam int TG = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic       pronto, ganhou, perdeu, db_timeout;
  logic [3:0] db_estado;
  int         total = 0;
  int         bad = 0;

  unidade_controle_rodadas_if dp();

  unidade_controle_rodadas #(.T_LED(TL), .T_GAP(TG)) dut (
    .clock      (clock),
    .reset      (reset),
    .iniciar    (iniciar),
    .dp         (dp),
    .pronto     (pronto),
    .ganhou     (ganhou),
    .perdeu     (perdeu),
    .db_timeout (db_timeout),
    .db_estado  (db_estado)
  );

  always #5 clock = ~clock;

  // datapath stand-in: address and round counters driven by the controller
  logic [3:0] m_end, m_rod;
  int         n_conta = 0;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_end <= 4'd0;
      m_rod <= 4'd0;
    end else begin
      if (dp.zera_endereco) m_end <= 4'd0;
      else if (dp.conta_endereco) m_end <= m_end + 4'd1;
      if (dp.zera_rodada) m_rod <= 4'd0;
      else if (dp.conta_rodada) m_rod <= m_rod + 4'd1;
    end
  end
  always @(posedge clock) if (!reset && dp.conta_rodada) n_conta <= n_conta + 1;
  assign dp.endereco_igual_rodada = (m_end == m_rod);
  assign dp.ultima_rodada         = (m_rod == 4'd15);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget);
    int n = 0;
    while (db_estado !== s && n < budget) begin
      @(negedge clock);
      n++;
    end
    check($sformatf("wait_state_%0h", s), {28'd0, db_estado}, {28'd0, s});
  endtask

  // counts lit cycles in mostra and dark cycles in apaga, from entry to mostra
  task automatic measure(output int led, output int gap);
    led = 0;
    gap = 0;
    while (db_estado == MOSTRA && led < 50) begin
      if (dp.mostra_led === 1'b1) led++;
      @(negedge clock);
    end
    while (db_estado == APAGA && gap < 50) begin
      if (dp.mostra_led === 1'b0) gap++;
      @(negedge clock);
    end
  endtask

  task automatic play(input logic ok, input logic [3:0] exp_next);
    wait_state(ESPERA_JOGADA, 300);
    dp.jogada_correta = ok;
    dp.tem_jogada     = 1'b1;
    @(negedge clock);
    dp.tem_jogada = 1'b0;
    check("registra", {28'd0, db_estado}, 32'h8);
    @(negedge clock);
    check("compara", {28'd0, db_estado}, 32'h9);
    @(negedge clock);
    check("apos_compara", {28'd0, db_estado}, {28'd0, exp_next});
    dp.jogada_correta = 1'b0;
  endtask

  task automatic start_game();
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    check("prep_estado", {28'd0, db_estado}, 32'h1);
    check("prep_zeros", {29'd0, dp.zera_endereco, dp.zera_rodada, dp.zera_timer}, 32'h7);
    check("prep_fim", {30'd0, pronto, ganhou}, 32'h0);
  endtask

  int led, gap, base;

  initial begin
    reset = 1'b1;
    iniciar = 1'b0;
    dp.tem_jogada = 1'b0;
    dp.jogada_correta = 1'b0;
    dp.timeout = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_estado", {28'd0, db_estado}, 32'h0);
    check("rst_saidas", {20'd0, dp.zera_endereco, dp.conta_endereco, dp.zera_rodada,
          dp.conta_rodada, dp.zera_timer, dp.conta_timer, dp.registra_jogada,
          dp.mostra_led, pronto, ganhou, perdeu, db_timeout}, 32'h0);
    reset = 1'b0;
    @(negedge clock);
    check("inicial_espera", {28'd0, db_estado}, 32'h0);

    // first round display timing
    start_game();
    @(negedge clock);
    check("mostra_entrada", {28'd0, db_estado}, 32'h3);
    measure(led, gap);
    check("led_ciclos", led, TL);
    check("gap_ciclos", gap, TG);
    check("inicio_jogadas", {28'd0, db_estado}, 32'h6);
    @(negedge clock);
    check("espera_jogada", {28'd0, db_estado}, 32'h7);

    // full 16-round win
    base = n_conta;
    for (int r = 0; r < 16; r++)
      for (int i = 0; i <= r; i++)
        play(1'b1, (i < r) ? 4'hA : ((r == 15) ? 4'hC : 4'hB));
    check("conta_rodada_pulsos", n_conta - base, 15);
    check("ganhou_saidas", {29'd0, pronto, ganhou, perdeu}, 32'h6);
    repeat (5) @(negedge clock);
    check("ganhou_mantem", {25'd0, db_estado, pronto, ganhou, perdeu}, {25'd0, 4'hC, 3'b110});

    // restart from win, lose on round 2 second play
    start_game();
    base = n_conta;
    play(1'b1, 4'hB);
    play(1'b1, 4'hA);
    play(1'b1, 4'hB);
    play(1'b1, 4'hA);
    play(1'b0, 4'hD);
    check("perdeu_saidas", {28'd0, pronto, ganhou, perdeu, db_timeout}, 32'hA);
    check("perdeu_rodadas", n_conta - base, 2);

    // timeout loss
    start_game();
    wait_state(ESPERA_JOGADA, 300);
    repeat (5) @(negedge clock);
    check("espera_fica", {27'd0, db_estado, dp.conta_timer}, {27'd0, 4'h7, 1'b1});
    dp.timeout = 1'b1;
    @(negedge clock);
    dp.timeout = 1'b0;
    check("timeout_estado", {28'd0, db_estado}, 32'hE);
    check("timeout_saidas", {28'd0, pronto, ganhou, perdeu, db_timeout}, 32'hB);

    // play and timeout together: play wins
    start_game();
    wait_state(ESPERA_JOGADA, 300);
    dp.timeout = 1'b1;
    dp.tem_jogada = 1'b1;
    dp.jogada_correta = 1'b1;
    @(negedge clock);
    dp.timeout = 1'b0;
    dp.tem_jogada = 1'b0;
    check("simultaneo_registra", {28'd0, db_estado}, 32'h8);
    @(negedge clock);
    @(negedge clock);
    check("simultaneo_rodada", {28'd0, db_estado}, 32'hB);
    dp.jogada_correta = 1'b0;

    // asynchronous reset in the middle of a LED display
    wait_state(MOSTRA, 50);
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("rst_async_estado", {28'd0, db_estado}, 32'h0);
    check("rst_async_saidas", {29'd0, dp.mostra_led, pronto, perdeu}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_apos", {27'd0, db_estado, dp.mostra_led}, 32'h0);
    start_game();
    @(negedge clock);
    measure(led, gap);
    check("rst_led_ciclos", led, TL);
    check("rst_gap_ciclos", gap, TG);
    check("rst_rodada0", {28'd0, db_estado}, 32'h6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
